// File: rtl/hetszegmens_pkg.sv
`default_nettype none
// ============================================================================
// hetszegmens_pkg : shared constants and hex-to-7-segment table (a=bit6..g=bit0)
// Revision 1.0 - initial release
// ============================================================================
package hetszegmens_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hetszegmens_mux_dekod.sv
`default_nettype none
// ============================================================================
// hetszeg_dekod : combinational nibble -> a..g segment pattern (1 = lit)
// Revision 1.0 - initial release
// ============================================================================
module hetszeg_dekod
    import hetszegmens_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_of(nibble_i);

endmodule
`default_nettype wire

// File: rtl/hetszegmens_mux.sv
`default_nettype none
// ============================================================================
// hetszegmens_mux : multiplexed DIGITS-digit hex 7-segment driver, frame-
// synchronous tear-free updates. HETSZEGMENS_LZB_EN enables leading-zero blanking.
// Revision 1.0 - initial release
// ============================================================================
module hetszegmens_mux
    import hetszegmens_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [7:0]        SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] AN_RST  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PCNT_W-1:0]   pcnt_q,       pcnt_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [4*DIGITS-1:0] active_q,     active_d;
    logic [DIGITS-1:0]   active_dp_q,  active_dp_d;
    logic [4*DIGITS-1:0] pending_q,    pending_d;
    logic [DIGITS-1:0]   pending_dp_q, pending_dp_d;
    logic                pend_valid_q, pend_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          seg_q,        seg_d;
    logic [DIGITS-1:0]   an_q,         an_d;

    logic                w_tick;
    logic                w_boundary;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg7;
    logic                w_blank;
    logic [7:0]          w_seg_lit;
    logic [DIGITS-1:0]   w_an_lit;

    assign w_tick     = (pcnt_q == PCNT_W'(PRESCALE - 1));
    assign w_boundary = w_tick && (idx_q == IDX_W'(DIGITS - 1));
    assign w_nibble   = active_q[4*idx_q +: 4];

    hetszeg_dekod u_dekod (
        .nibble_i (w_nibble),
        .seg_o    (w_seg7)
    );

`ifdef HETSZEGMENS_LZB_EN
    // Blank when this digit and every more-significant digit are zero.
    assign w_blank = (idx_q != '0) && ((active_q >> (4*idx_q)) == '0);
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg_lit = {active_dp_q[idx_q], w_blank ? 7'h00 : w_seg7};
    assign w_an_lit  = DIGITS'(1) << idx_q;

    always_comb begin
        pcnt_d       = w_tick ? '0 : pcnt_q + 1'b1;
        idx_d        = idx_q;
        active_d     = active_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        pending_dp_d = pending_dp_q;
        pend_valid_d = pend_valid_q;
        frame_done_d = w_boundary;
        seg_d        = (SEG_ACTIVE_LOW != 0) ? ~w_seg_lit : w_seg_lit;
        an_d         = (AN_ACTIVE_LOW != 0)  ? ~w_an_lit  : w_an_lit;

        if (w_tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // A load landing on the boundary bypasses the pending stage entirely.
        if (w_boundary) begin
            if (load) begin
                active_d    = data_in;
                active_dp_d = dp_in;
            end else if (pend_valid_q) begin
                active_d    = pending_q;
                active_dp_d = pending_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pending_d    = data_in;
            pending_dp_d = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pending_q    <= '0;
            pending_dp_q <= '0;
            pend_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_RST;
            an_q         <= AN_RST;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            pending_dp_q <= pending_dp_d;
            pend_valid_q <= pend_valid_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hetszegmens_mux.sv
`default_nettype none
// ============================================================================
// tb_hetszegmens_mux : self-checking bench, time-based display model plus
// hand-computed checkpoints; second instance covers inverted polarity.
// ============================================================================
module tb_hetszegmens_mux;

`ifdef HETSZEGMENS_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam int P = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    logic [15:0] data2 = '0;
    logic [3:0]  dp2 = '0;
    logic        load2 = 1'b0;
    logic [7:0]  seg2;
    logic [3:0]  an2;
    logic        fd2;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    hetszegmens_mux #(.DIGITS(D), .PRESCALE(P), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    hetszegmens_mux #(.DIGITS(4), .PRESCALE(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .data_in(data2), .dp_in(dp2), .load(load2),
        .seg(seg2), .an(an2), .frame_done(fd2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Hex glyph for a digit position of a 16-bit value, with optional blanking.
    function automatic logic [7:0] glyph(input int d, input logic [15:0] v, input logic [3:0] dp);
        logic [3:0]  n;
        logic [15:0] upper;
        logic [6:0]  s;
        upper = v >> (4*d);
        n = upper[3:0];
        case (n)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
        endcase
        if (LZB && d > 0 && upper == 16'h0) s = 7'h00;
        return {dp[d], s};
    endfunction

    // Model: cycle k after reset lights digit (k/P)%D; frame ends when k%(P*D)==P*D-1.
    int          m_t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pv;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd;

    always @(posedge clk) begin
        if (rst) begin
            m_t <= 0; m_act <= '0; m_act_dp <= '0; m_pend <= '0; m_pend_dp <= '0; m_pv <= 1'b0;
            e_seg <= 8'h00; e_an <= 4'h0; e_fd <= 1'b0;
        end else begin
            e_seg <= glyph((m_t / P) % D, m_act, m_act_dp);
            e_an  <= 4'(1 << ((m_t / P) % D));
            e_fd  <= ((m_t % (P*D)) == P*D - 1);
            m_t   <= m_t + 1;
            if ((m_t % (P*D)) == P*D - 1) begin
                if (load) begin
                    m_act <= data_in; m_act_dp <= dp_in;
                end else if (m_pv) begin
                    m_act <= m_pend; m_act_dp <= m_pend_dp;
                end
                m_pv <= 1'b0;
            end else if (load) begin
                m_pend <= data_in; m_pend_dp <= dp_in; m_pv <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_an", 32'(an), 32'(e_an));
            chk("model_frame_done", 32'(frame_done), 32'(e_fd));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk_en = 1'b1;
        rst = 1'b0;

        cyc(1);  chk("idle_seg0", 32'(seg), 32'h7E); chk("idle_an0", 32'(an), 32'h1);
        cyc(4);  chk("idle_an1", 32'(an), 32'h2);
        cyc(11); chk("fd_pulse", 32'(frame_done), 32'h1); chk("idle_an3", 32'(an), 32'h8);
        cyc(1);  chk("fd_low", 32'(frame_done), 32'h0); chk("wrap_an0", 32'(an), 32'h1);
        cyc(47);
        data_in = 16'h12AF; load = 1'b1;
        cyc(1);  load = 1'b0;
        cyc(6);  chk("pending_hidden", 32'(seg), 32'h7E);
        cyc(10); chk("d0_F", 32'(seg), 32'h47);
        cyc(4);  chk("d1_A", 32'(seg), 32'h77);
        cyc(4);  chk("d2_2", 32'(seg), 32'h6D);
        cyc(4);  chk("d3_1", 32'(seg), 32'h30);
        cyc(2);
        data_in = 16'h0009; load = 1'b1;
        cyc(1);  load = 1'b0;
        cyc(1);  chk("bnd_load_d0", 32'(seg), 32'h7B);
        cyc(4);  chk("bnd_load_d1", 32'(seg), LZB ? 32'h00 : 32'h7E);
        cyc(12); chk("no_stale_pend", 32'(seg), 32'h7B);
        data_in = 16'h0880; dp_in = 4'b0100; load = 1'b1;
        cyc(1);  load = 1'b0; dp_in = 4'b0000;
        cyc(15); chk("dp_d0", 32'(seg), 32'h7E);
        cyc(4);  chk("dp_d1", 32'(seg), 32'h7F);
        cyc(4);  chk("dp_d2", 32'(seg), 32'hFF);
        cyc(4);  chk("dp_d3", 32'(seg), LZB ? 32'h00 : 32'h7E);
        data_in = 16'h0050; load = 1'b1;
        cyc(1);  load = 1'b0;
        cyc(3);  chk("lzb_d0", 32'(seg), 32'h7E);
        cyc(4);  chk("lzb_d1", 32'(seg), 32'h5B);
        cyc(4);  chk("lzb_d2", 32'(seg), LZB ? 32'h00 : 32'h7E);
        cyc(4);  chk("lzb_d3", 32'(seg), LZB ? 32'h00 : 32'h7E);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("inv_rst_seg", 32'(seg2), 32'hFF); chk("inv_rst_an", 32'(an2), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h00);   chk("midrst_an", 32'(an), 32'h0);
        rst = 1'b0;
        cyc(1);
        chk("inv_seg", 32'(seg2), 32'h81);     chk("inv_an", 32'(an2), 32'hE);
        chk("post_rst_seg", 32'(seg), 32'h7E); chk("post_rst_an", 32'(an), 32'h1);
        cyc(20);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
